// File: rtl/uart_tx_port_pkg.sv
// Shared constants for the UART transmit port: peripheral address prefixes,
// transmitter state encoding and status-word bit positions.
package uart_tx_port_pkg;

    localparam logic [2:0] PERIPH_RAM  = 3'b000;
    localparam logic [2:0] PERIPH_PWM  = 3'b001;
    localparam logic [2:0] PERIPH_BTN  = 3'b010;
    localparam logic [2:0] PERIPH_UART = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

endpackage

// File: rtl/uart_tx_port_if.sv
// Peripheral-manager side of the UART port: decoded write strobes, write data,
// status-read select and the combinational status word.
interface uart_tx_port_if;
    logic        write_data;
    logic        write_div;
    logic [31:0] mem_data;
    logic        read_status;
    logic [31:0] status_out;

    modport master (
        output write_data, write_div, mem_data, read_status,
        input  status_out
    );

    modport slave (
        input  write_data, write_div, mem_data, read_status,
        output status_out
    );
endinterface

// File: rtl/uart_tx_port_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; a push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO, programmable baud divisor,
// registered serial output and a combinational status word.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_IDLE  | line high, waiting for a byte in the FIFO
//   ST_START | start bit (low) held for one bit time
//   ST_DATA  | data bits, LSB first, bit index in idx_q
//   ST_STOP  | stop bit (high); at its end chain the next frame or idle
module uart_tx_port
    import uart_tx_port_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int DEFAULT_DIV = 234,
    parameter int DIV_WIDTH   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_port_if.slave  bus,
    output logic           tx_out,
    output logic           busy
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    tx_state_e            state_q, state_d;
    logic [DIV_WIDTH-1:0] div_cfg_q, div_cfg_d;
    logic [DIV_WIDTH-1:0] div_act_q, div_act_d;
    logic [DIV_WIDTH-1:0] timer_q, timer_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           idx_q, idx_d;
    logic                 tx_q, tx_d;
    logic                 ovf_q, ovf_d;

    logic                 fifo_pop, fifo_full, fifo_empty;
    logic [7:0]           fifo_head;
    logic [CNT_W-1:0]     fifo_count;
    logic                 timer_tc;
    logic [DIV_WIDTH-1:0] div_wr_val;
    logic                 unused_mem_bits;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .CW    (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.write_data),
        .pop   (fifo_pop),
        .wdata (bus.mem_data[7:0]),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign timer_tc        = (timer_q == div_act_q - DIV_WIDTH'(1));
    assign div_wr_val      = bus.mem_data[DIV_WIDTH-1:0];
    assign unused_mem_bits = ^bus.mem_data[31:DIV_WIDTH];

    always_comb begin
        state_d   = state_q;
        div_act_d = div_act_q;
        timer_d   = timer_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_head;
                    div_act_d = div_cfg_q;
                    tx_d      = 1'b0;
                    timer_d   = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                timer_d = timer_q + DIV_WIDTH'(1);
                if (timer_tc) begin
                    timer_d = '0;
                    tx_d    = shift_q[0];
                    idx_d   = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                timer_d = timer_q + DIV_WIDTH'(1);
                if (timer_tc) begin
                    timer_d = '0;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                timer_d = timer_q + DIV_WIDTH'(1);
                if (timer_tc) begin
                    timer_d = '0;
                    // Chain straight into the next start bit so there is no idle gap.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_head;
                        div_act_d = div_cfg_q;
                        tx_d      = 1'b0;
                        state_d   = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        div_cfg_d = div_cfg_q;
        if (bus.write_div && (div_wr_val > DIV_WIDTH'(1))) div_cfg_d = div_wr_val;
    end

    // A fresh overflow wins over a clear-on-read in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (bus.write_data && fifo_full && !fifo_pop) ovf_d = 1'b1;
        else if (bus.read_status)                     ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            div_cfg_q <= DIV_WIDTH'(DEFAULT_DIV);
            div_act_q <= DIV_WIDTH'(DEFAULT_DIV);
            timer_q   <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cfg_q <= div_cfg_d;
            div_act_q <= div_act_d;
            timer_q   <= timer_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

    assign tx_out = tx_q;
    assign busy   = (state_q != ST_IDLE) | ~fifo_empty;

    always_comb begin
        bus.status_out                     = '0;
        bus.status_out[STAT_BUSY]          = busy;
        bus.status_out[STAT_FULL]          = fifo_full;
        bus.status_out[STAT_EMPTY]         = fifo_empty;
        bus.status_out[STAT_OVF]           = ovf_q;
        bus.status_out[STAT_CNT_LSB +: 4]  = 4'(fifo_count);
    end
endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: a queue-based line model checked every cycle, a
// table of single-frame vectors, directed corner sequences and a random phase.
module tb_uart_tx_port;
    localparam int DEPTH   = 4;
    localparam int DEF_DIV = 234;
    localparam int DW      = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_out, busy;

    uart_tx_port_if bus ();

    uart_tx_port #(
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (DEF_DIV),
        .DIV_WIDTH   (DW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .tx_out (tx_out),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: bytes waiting, and line levels still to be shown (head = current level).
    logic [7:0] m_fifo [$];
    logic       m_line [$];
    int         m_div;
    logic       m_ovf;

    typedef struct {
        logic [15:0] wdiv;
        logic [7:0]  data;
        int          exp_len;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_fifo.delete();
        m_line.delete();
        m_div = DEF_DIV;
        m_ovf = 1'b0;
    endfunction

    function automatic void model_edge(input logic wd, input logic wv,
                                       input logic [31:0] md, input logic rs);
        logic [7:0] b;
        logic       rej;
        logic       lvl;
        if (m_line.size() > 0) void'(m_line.pop_front());
        if (m_line.size() == 0 && m_fifo.size() > 0) begin
            b = m_fifo.pop_front();
            for (int k = 0; k < 10; k++) begin
                lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                for (int j = 0; j < m_div; j++) m_line.push_back(lvl);
            end
        end
        rej = 1'b0;
        if (wd) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(md[7:0]);
            else rej = 1'b1;
        end
        if (rej)     m_ovf = 1'b1;
        else if (rs) m_ovf = 1'b0;
        if (wv && md[15:0] >= 16'd2) m_div = int'(md[15:0]);
    endfunction

    function automatic logic m_tx();
        return (m_line.size() > 0) ? m_line[0] : 1'b1;
    endfunction

    function automatic logic m_busy();
        return (m_line.size() > 0) || (m_fifo.size() > 0);
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s    = '0;
        s[0] = m_busy();
        s[1] = (m_fifo.size() == DEPTH);
        s[2] = (m_fifo.size() == 0);
        s[3] = m_ovf;
        s[7:4] = 4'(m_fifo.size());
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge(bus.write_data, bus.write_div, bus.mem_data, bus.read_status);
        else       model_reset();
        #1;
        chk("tx_out", {31'b0, tx_out}, {31'b0, m_tx()});
        chk("busy", {31'b0, busy}, {31'b0, m_busy()});
        chk("status", bus.status_out, m_status());
        bus.write_data  = 1'b0;
        bus.write_div   = 1'b0;
        bus.read_status = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        bus.write_data = 1'b1;
        bus.mem_data   = {24'b0, b};
        tick();
    endtask

    task automatic set_div(input logic [31:0] d);
        bus.write_div = 1'b1;
        bus.mem_data  = d;
        tick();
    endtask

    task automatic run_until_idle(input int max, output int n);
        n = 0;
        while (busy === 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        bus.write_data  = 1'b0;
        bus.write_div   = 1'b0;
        bus.read_status = 1'b0;
        bus.mem_data    = '0;
        model_reset();

        vecs[0] = '{16'd4, 8'hA5, 40};
        vecs[1] = '{16'd1, 8'h3C, 40};
        vecs[2] = '{16'd0, 8'h81, 40};
        vecs[3] = '{16'd2, 8'hFF, 20};
        vecs[4] = '{16'd3, 8'h00, 30};
        vecs[5] = '{16'd5, 8'h5A, 50};

        // Reset state
        repeat (3) tick();
        chk("reset_tx", {31'b0, tx_out}, 32'd1);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_status", bus.status_out, 32'h0000_0004);
        rst_n = 1'b1;
        tick();

        // Single frames; frame length measured from the first low bit to busy low
        for (int v = 0; v < 6; v++) begin
            set_div({16'b0, vecs[v].wdiv});
            push(vecs[v].data);
            run_until_idle(2000, n);
            chk($sformatf("frame_len_%0d", v), n - 1, vecs[v].exp_len);
            tick();
        end

        // Three back-to-back frames with no idle gap
        set_div(32'd4);
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        run_until_idle(1000, n);
        chk("b2b_total", n + 1, 120);
        tick();

        // Overflow: 6 pushes while idle, one byte popped after the first
        for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
        chk("ovf_set", {31'b0, bus.status_out[3]}, 32'd1);
        chk("ovf_full", {31'b0, bus.status_out[1]}, 32'd1);
        chk("ovf_count", {28'b0, bus.status_out[7:4]}, 32'd4);
        bus.read_status = 1'b1;
        #1;
        chk("ovf_during_read", {31'b0, bus.status_out[3]}, 32'd1);
        tick();
        chk("ovf_cleared", {31'b0, bus.status_out[3]}, 32'd0);
        run_until_idle(2000, n);
        tick();

        // Divisor change mid-frame: current frame keeps div 4, next uses 8
        push(8'hC3);
        repeat (10) tick();
        set_div(32'd8);
        push(8'h3C);
        run_until_idle(2000, n);
        chk("div_change_total", 12 + n, 121);
        set_div(32'd1);
        push(8'h96);
        run_until_idle(2000, n);
        chk("div1_ignored_len", n - 1, 80);
        tick();

        // Asynchronous reset during DATA
        set_div(32'd4);
        push(8'hA5);
        repeat (12) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_tx", {31'b0, tx_out}, 32'd1);
        chk("rst_async_status", bus.status_out, 32'h0000_0004);
        repeat (2) tick();
        rst_n = 1'b1;
        push(8'h01);
        run_until_idle(5000, n);
        chk("rst_default_div_len", n - 1, 10 * DEF_DIV);
        tick();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.write_data = 1'b1;
                bus.mem_data   = $urandom;
            end else if ($urandom_range(0, 39) == 0) begin
                bus.write_div = 1'b1;
                bus.mem_data  = {$urandom_range(0, 65535), 16'(0)} | 32'($urandom_range(0, 5));
            end
            if ($urandom_range(0, 7) == 0) bus.read_status = 1'b1;
            tick();
        end
        run_until_idle(5000, n);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
- Memory-mapped UART transmitter peripheral at address prefix 3'b011.
- Sits directly downstream of the peripheral manager, which decodes the address and drives the write strobes, the data word and the status-read select.
- Buffers bytes in a small FIFO and serialises them as 8N1 frames on a single output pin.
- Baud divisor is software-programmable.

Parameters:
- FIFO_DEPTH, 4: byte FIFO entries; must be a power of 2, at least 2.
- DEFAULT_DIV, 234: reset baud divisor in clk cycles per bit (27 MHz / 115200).
- DIV_WIDTH, 16: width of the baud divisor and bit-timer counter.

Ports:
- clk  in  1  processor clock
- rst_n  in  1  asynchronous active-low reset
- write_data  in  1  push mem_data[7:0] into FIFO (decoded addr 011x...x0 with write)
- write_div  in  1  load mem_data[DIV_WIDTH-1:0] as baud divisor (011x...x1 with write)
- mem_data  in  32  write data from peripheral manager
- read_status  in  1  status register is being read this cycle
- status_out  out  32  combinational status word
- tx_out  out  1  serial line, idle high
- busy  out  1  high while a frame is in flight or FIFO non-empty

Behaviour:
Reset (asynchronous, while rst_n=0):
- tx_out=1, busy=0, FIFO empty, overflow=0, divisor=DEFAULT_DIV, FSM=IDLE.
- Deasserting reset mid-frame abandons the frame; the line stays high.

FIFO:
- write_data high at edge E with FIFO not full: byte stored at E.
- Write when full: byte dropped, sticky overflow set.
- Simultaneous pop and push when full: both happen; the write is accepted and overflow stays clear.
- Pointers wrap modulo FIFO_DEPTH; count is kept in FIFO_DEPTH+1 states.

Divisor:
- write_div with value 0 or 1 is ignored (divisor stays ≥2).
- A new divisor is latched into the active divisor only when a frame starts; a frame in flight keeps its timing.

FSM states IDLE, START, DATA, STOP:
- IDLE: if FIFO non-empty at an edge, pop the head byte into the shift register, latch the divisor, set tx_out=0, clear the bit timer, go to START.
  - A byte written at edge E into an empty FIFO while IDLE gives tx_out low after edge E+1.
- START: hold for div cycles, then tx_out=shift[0], bit index=0, go to DATA.
- DATA: each bit is held div cycles, LSB first. After bit 7, tx_out=1 and go to STOP.
- STOP: hold for div cycles. At the end:
  - If the FIFO is non-empty, pop and go straight to START (no idle gap).
  - Otherwise go to IDLE.
- Frame length is exactly 10*div cycles.
- Bit timer counts 0..div-1 and wraps. The terminal count advances the state.

Outputs:
- busy = (state != IDLE) | !empty.
- status_out, combinational:
  - [0] busy
  - [1] full
  - [2] empty
  - [3] overflow
  - [7:4] FIFO count (zero-extended/truncated)
  - [31:8] = 0
- Overflow clears at the edge following any cycle with read_status=1. status_out in that cycle still shows 1.
- A write and a read in the same cycle that causes a new overflow leaves overflow set.

Decomposition:
- Shared package: peripheral prefix constants (PERIPH_RAM=3'b000, PERIPH_PWM=3'b001, PERIPH_BTN=3'b010, PERIPH_UART=3'b011), FSM state encoding, status bit index constants.
- One natural sub-module, sync_fifo (parameterised width/depth, push/pop/full/empty/count), instantiated once with width 8.

Test Plan:
- Reset, DEFAULT_DIV: tx_out=1, busy=0, status_out=32'h0000_0004.
- write_div 4, then write_data 8'hA5 at edge E: tx_out low after E+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high 4 cycles; busy falls after 40 cycles.
- div=4, push 8'h00, 8'hFF, 8'h55 on consecutive cycles: three frames back-to-back, 120 cycles total, no idle high between stop and next start.
- div=4, push 6 bytes on consecutive cycles while IDLE (one pop after first): FIFO holds 4, one byte dropped. status_out[3]=1 and [1]=1. After a read_status cycle, [3]=0.
- Mid-frame write_div 8 during a div=4 frame: the current frame stays 40 cycles and the next frame is 80 cycles. write_div 1 is ignored (divisor stays 8).
- Assert rst_n=0 during DATA: tx_out=1 immediately (asynchronous), FIFO empty, divisor back to 234.
